// File: rtl/mem_req_initiator_if.sv
// rtl/mem_req_initiator_if.sv - cache-side request/response and memory-side message bus bundle
interface mem_req_initiator_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0]    req_data;

    logic                     resp_valid;
    logic                     resp_write;
    logic [ADDRESS_WIDTH-1:0] resp_address;
    logic [DATA_WIDTH-1:0]    resp_data;

    logic [MSG_BITS-1:0]      mem_msg_out;
    logic [ADDRESS_WIDTH-1:0] mem_address_out;
    logic [DATA_WIDTH-1:0]    mem_data_out;
    logic [MSG_BITS-1:0]      mem_msg_in;
    logic [ADDRESS_WIDTH-1:0] mem_address_in;
    logic [DATA_WIDTH-1:0]    mem_data_in;

    logic                     busy;
    logic                     timeout_error;

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        input  mem_msg_in, mem_address_in, mem_data_in,
        output req_ready,
        output resp_valid, resp_write, resp_address, resp_data,
        output mem_msg_out, mem_address_out, mem_data_out,
        output busy, timeout_error
    );

    modport master (
        output req_valid, req_write, req_address, req_data,
        output mem_msg_in, mem_address_in, mem_data_in,
        input  req_ready,
        input  resp_valid, resp_write, resp_address, resp_data,
        input  mem_msg_out, mem_address_out, mem_data_out,
        input  busy, timeout_error
    );
endinterface

// File: rtl/mem_req_initiator.sv
// rtl/mem_req_initiator.sv - queued read-fill/write-back initiator for one main_memory port
module mem_req_initiator #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 4,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clock,
    input  logic                reset,
    mem_req_initiator_if.slave  bus
);
    localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(10);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] T_LIM  = CW'(TIMEOUT_CYCLES);
    localparam logic [PW:0]   Q_FULL = (PW+1)'(QUEUE_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic                     q_write   [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] q_address [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]    q_data    [QUEUE_DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [PW:0]              count;
    logic                     full, empty, push, pop;

    state_t                   state_q, state_d;
    logic [MSG_BITS-1:0]      msg_q, msg_d;
    logic [ADDRESS_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0]    mdata_q, mdata_d;
    logic                     rvalid_q, rvalid_d;
    logic                     rwrite_q, rwrite_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     terr_q, terr_d;
    logic                     match;

    assign full  = (count == Q_FULL);
    assign empty = (count == '0);
    // Gated by reset so the cache sees no room while the block is held in reset.
    assign bus.req_ready = reset && !full;
    assign push  = bus.req_valid && bus.req_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            q_write[wr_ptr]   <= bus.req_write;
            q_address[wr_ptr] <= bus.req_address;
            q_data[wr_ptr]    <= bus.req_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign match = (bus.mem_msg_in == MEM_RESP) && (bus.mem_address_in == maddr_q);

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        rvalid_d = 1'b0;
        rwrite_d = 1'b0;
        raddr_d  = '0;
        rdata_d  = '0;
        cnt_d    = cnt_q;
        terr_d   = terr_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    msg_d   = q_write[rd_ptr] ? WB_REQ : R_REQ;
                    maddr_d = q_address[rd_ptr];
                    mdata_d = q_write[rd_ptr] ? q_data[rd_ptr] : '0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The head stays queued until memory answers, so it still describes the request.
                if (match) begin
                    pop      = 1'b1;
                    msg_d    = NO_REQ;
                    maddr_d  = '0;
                    mdata_d  = '0;
                    rvalid_d = 1'b1;
                    rwrite_d = q_write[rd_ptr];
                    raddr_d  = maddr_q;
                    rdata_d  = q_write[rd_ptr] ? '0 : bus.mem_data_in;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q != T_LIM)) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == T_LIM) terr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            msg_q    <= NO_REQ;
            maddr_q  <= '0;
            mdata_q  <= '0;
            rvalid_q <= 1'b0;
            rwrite_q <= 1'b0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            rvalid_q <= rvalid_d;
            rwrite_q <= rwrite_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.mem_msg_out     = msg_q;
    assign bus.mem_address_out = maddr_q;
    assign bus.mem_data_out    = mdata_q;
    assign bus.resp_valid      = rvalid_q;
    assign bus.resp_write      = rwrite_q;
    assign bus.resp_address    = raddr_q;
    assign bus.resp_data       = rdata_q;
    assign bus.timeout_error   = terr_q;
    assign bus.busy            = !empty || (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_req_initiator.sv
// tb/tb_mem_req_initiator.sv - directed self-checking bench for mem_req_initiator
module tb_mem_req_initiator;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 4;
    localparam int QD = 4;
    localparam int TO = 8;
    localparam logic [3:0] NO_REQ = 4'd0, R_REQ = 4'd1, WB_REQ = 4'd2, MEM_RESP = 4'd10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_req_initiator_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB)) bus();

    mem_req_initiator #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB),
        .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // Idle single-port memory: write-backs answer one edge after seeing the request, reads two.
    logic        stall;
    logic [31:0] mem_arr [0:255];
    logic [3:0]  m_msg;
    logic [31:0] m_addr, m_data, lat_addr;
    logic [1:0]  mstate;
    logic        inj_en;
    logic [3:0]  inj_msg;
    logic [31:0] inj_addr, inj_data;

    always @(posedge clock) begin
        if (!reset) begin
            mstate <= 2'd0;
            m_msg  <= NO_REQ;
            m_addr <= 32'd0;
            m_data <= 32'd0;
        end else begin
            m_msg <= NO_REQ;
            if (!stall) begin
                case (mstate)
                    2'd0: begin
                        if (bus.mem_msg_out == WB_REQ) begin
                            mem_arr[bus.mem_address_out[7:0]] <= bus.mem_data_out;
                            m_msg  <= MEM_RESP;
                            m_addr <= bus.mem_address_out;
                            m_data <= 32'd0;
                            mstate <= 2'd2;
                        end else if (bus.mem_msg_out == R_REQ) begin
                            lat_addr <= bus.mem_address_out;
                            mstate   <= 2'd1;
                        end
                    end
                    2'd1: begin
                        m_msg  <= MEM_RESP;
                        m_addr <= lat_addr;
                        m_data <= mem_arr[lat_addr[7:0]];
                        mstate <= 2'd2;
                    end
                    default: mstate <= 2'd0;
                endcase
            end
        end
    end

    assign bus.mem_msg_in     = inj_en ? inj_msg  : m_msg;
    assign bus.mem_address_in = inj_en ? inj_addr : m_addr;
    assign bus.mem_data_in    = inj_en ? inj_data : m_data;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_address = a;
        bus.req_data    = d;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = 32'd0;
        bus.req_data    = 32'd0;
    endtask

    task automatic wait_resp(input string tag, output logic w, output logic [31:0] a,
                             output logic [31:0] d, output logic rdy);
        int n = 0;
        while (!bus.resp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_seen"}, {31'd0, bus.resp_valid}, 32'd1);
        w   = bus.resp_write;
        a   = bus.resp_address;
        d   = bus.resp_data;
        rdy = bus.req_ready;
        @(negedge clock);
        check({tag, "_pulse_end"}, {31'd0, bus.resp_valid}, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "_msg"}, {28'd0, bus.mem_msg_out}, 32'd0);
        check({tag, "_maddr"}, bus.mem_address_out, 32'd0);
        check({tag, "_mdata"}, bus.mem_data_out, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_timeout"}, {31'd0, bus.timeout_error}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    logic        rw, rr;
    logic [31:0] ra, rd;
    logic        exp_w [4];
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0;
        bus.req_address = 32'd0; bus.req_data = 32'd0;
        stall = 1'b0; inj_en = 1'b0; inj_msg = NO_REQ; inj_addr = 32'd0; inj_data = 32'd0;

        #2 reset = 1'b0;
        #1 check_zero_outputs("rst");
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        #1 check("rst_ready_after", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clock);

        // Write-back then read of the same line.
        send(1'b1, 32'h10, 32'hA5A5_0001);
        check("wb_e0_msg", {28'd0, bus.mem_msg_out}, {28'd0, NO_REQ});
        @(negedge clock);
        check("wb_e1_msg", {28'd0, bus.mem_msg_out}, {28'd0, WB_REQ});
        check("wb_e1_addr", bus.mem_address_out, 32'h10);
        check("wb_e1_data", bus.mem_data_out, 32'hA5A5_0001);
        @(negedge clock);
        check("wb_e2_valid", {31'd0, bus.resp_valid}, 32'd0);
        wait_resp("wb", rw, ra, rd, rr);
        check("wb_write", {31'd0, rw}, 32'd1);
        check("wb_addr", ra, 32'h10);
        check("wb_data", rd, 32'd0);
        @(negedge clock);
        send(1'b0, 32'h10, 32'h0);
        @(negedge clock);
        check("rd_e1_msg", {28'd0, bus.mem_msg_out}, {28'd0, R_REQ});
        check("rd_e1_data", bus.mem_data_out, 32'd0);
        wait_resp("rd", rw, ra, rd, rr);
        check("rd_write", {31'd0, rw}, 32'd0);
        check("rd_addr", ra, 32'h10);
        check("rd_data", rd, 32'hA5A5_0001);
        @(negedge clock);

        // Read latency: resp_valid only in the cycle after edge 4.
        send(1'b0, 32'h10, 32'h0);
        check("lat_busy", {31'd0, bus.busy}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("lat_valid_e%0d", k), {31'd0, bus.resp_valid}, {31'd0, (k == 4)});
            if (k == 4) check("lat_data", bus.resp_data, 32'hA5A5_0001);
            @(negedge clock);
        end
        check("lat_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Wrong-address MEM_RESP is ignored.
        stall = 1'b1;
        send(1'b0, 32'h40, 32'h0);
        @(negedge clock);
        check("bad_e1_msg", {28'd0, bus.mem_msg_out}, {28'd0, R_REQ});
        inj_en = 1'b1; inj_msg = MEM_RESP; inj_addr = 32'h44; inj_data = 32'hDEAD;
        @(negedge clock);
        check("bad_no_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("bad_msg_held", {28'd0, bus.mem_msg_out}, {28'd0, R_REQ});
        check("bad_addr_held", bus.mem_address_out, 32'h40);
        inj_addr = 32'h40; inj_data = 32'h1234;
        @(negedge clock);
        inj_en = 1'b0; inj_msg = NO_REQ; inj_addr = 32'd0; inj_data = 32'd0;
        check("good_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("good_addr", bus.resp_address, 32'h40);
        check("good_data", bus.resp_data, 32'h1234);
        check("good_msg_cleared", {28'd0, bus.mem_msg_out}, {28'd0, NO_REQ});
        stall = 1'b0;
        @(negedge clock); @(negedge clock);

        // Timeout with a silent memory.
        stall = 1'b1;
        send(1'b0, 32'h80, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            check($sformatf("to_e%0d", k), {31'd0, bus.timeout_error}, {31'd0, (k == 9)});
        end
        repeat (3) @(negedge clock);
        check("to_sticky", {31'd0, bus.timeout_error}, 32'd1);
        check("to_msg_held", {28'd0, bus.mem_msg_out}, {28'd0, R_REQ});
        reset = 1'b0;
        #1 check_zero_outputs("to_rst");
        @(negedge clock);
        reset = 1'b1; stall = 1'b0;
        @(negedge clock);

        // Fill the queue while memory stalls, then drain in order.
        stall = 1'b1;
        exp_w[0] = 1'b1; exp_a[0] = 32'h100; exp_d[0] = 32'd0;
        exp_w[1] = 1'b1; exp_a[1] = 32'h104; exp_d[1] = 32'd0;
        exp_w[2] = 1'b0; exp_a[2] = 32'h100; exp_d[2] = 32'h11;
        exp_w[3] = 1'b0; exp_a[3] = 32'h104; exp_d[3] = 32'h22;
        send(1'b1, 32'h100, 32'h11);
        send(1'b1, 32'h104, 32'h22);
        send(1'b0, 32'h100, 32'h0);
        check("fill3_ready", {31'd0, bus.req_ready}, 32'd1);
        send(1'b0, 32'h104, 32'h0);
        check("fill4_ready", {31'd0, bus.req_ready}, 32'd0);
        check("fill4_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clock);
        check("full_hold_ready", {31'd0, bus.req_ready}, 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_resp($sformatf("fifo%0d", i), rw, ra, rd, rr);
            check($sformatf("fifo%0d_write", i), {31'd0, rw}, {31'd0, exp_w[i]});
            check($sformatf("fifo%0d_addr", i), ra, exp_a[i]);
            check($sformatf("fifo%0d_data", i), rd, exp_d[i]);
            if (i == 0) check("fifo_ready_after_pop", {31'd0, rr}, 32'd1);
        end
        check("fifo_drained_busy", {31'd0, bus.busy}, 32'd0);
        check("fifo_no_timeout", {31'd0, bus.timeout_error}, 32'd0);

        // Reset in WAIT with two entries queued.
        stall = 1'b1;
        send(1'b0, 32'h200, 32'h0);
        send(1'b0, 32'h204, 32'h0);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        check("mid_msg", {28'd0, bus.mem_msg_out}, {28'd0, R_REQ});
        reset = 1'b0;
        #1 check_zero_outputs("mid_rst");
        @(negedge clock); @(negedge clock);
        reset = 1'b1; stall = 1'b0;
        #1 check("mid_ready", {31'd0, bus.req_ready}, 32'd1);
        check("mid_busy_after", {31'd0, bus.busy}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("mid_no_resp%0d", k), {31'd0, bus.resp_valid}, 32'd0);
        end
        send(1'b0, 32'h10, 32'h0);
        wait_resp("post", rw, ra, rd, rr);
        check("post_addr", ra, 32'h10);
        check("post_data", rd, 32'hA5A5_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
